// File: rtl/reg_file_if.sv
// Register-file port bundle: two combinational read ports, one write-back port and
// the ready flag that gates core fetch until the post-reset clear has finished.
interface reg_file_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32
);
  localparam int unsigned AW = $clog2(NREG);

  logic [AW-1:0]   ra1;
  logic [AW-1:0]   ra2;
  logic [XLEN-1:0] rd1;
  logic [XLEN-1:0] rd2;
  logic            we;
  logic [AW-1:0]   wa;
  logic [XLEN-1:0] wd;
  logic            ready;

  // Core side: drives addresses and write-back, consumes operands and ready.
  modport master (
    output ra1, ra2, we, wa, wd,
    input  rd1, rd2, ready
  );

  // Register-file side.
  modport slave (
    input  ra1, ra2, we, wa, wd,
    output rd1, rd2, ready
  );
endinterface

// File: rtl/reg_file.sv
// Integer register file with hard-wired x0, optional write-to-read bypass and a
// post-reset clear sequencer that walks x1..x(NREG-1) so the array needs no reset.
module reg_file #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NREG   = 32,
  parameter bit          BYPASS = 1'b1
) (
  input logic       clk,
  input logic       rst,
  reg_file_if.slave bus
);
  localparam int unsigned AW = $clog2(NREG);

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t          state;
  logic [AW-1:0]   cnt;
  logic            ready_q;
  logic            last_clear;
  logic            wr_ok;
  logic [XLEN-1:0] regs [NREG];

  assign last_clear = (cnt == AW'(NREG - 1));
  // Writes to x0 are dropped, so they can neither update the array nor bypass.
  assign wr_ok      = bus.we && (bus.wa != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      cnt     <= AW'(1);
      ready_q <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          cnt <= cnt + 1'b1;
          if (last_clear) begin
            state   <= RUN;
            ready_q <= 1'b1;
          end
        end
        RUN: begin
          ready_q <= 1'b1;
        end
        default: begin
          state   <= CLEAR;
          cnt     <= AW'(1);
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  // Array has no reset branch; the sequencer zeroes one entry per edge while in CLEAR
  // and write-back is ignored until RUN.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) begin
        regs[cnt] <= '0;
      end else if (wr_ok) begin
        regs[bus.wa] <= bus.wd;
      end
    end
  end

  always_comb begin
    bus.rd1 = '0;
    if (ready_q && (bus.ra1 != '0)) begin
      if (BYPASS && wr_ok && (bus.wa == bus.ra1)) begin
        bus.rd1 = bus.wd;
      end else begin
        bus.rd1 = regs[bus.ra1];
      end
    end
  end

  always_comb begin
    bus.rd2 = '0;
    if (ready_q && (bus.ra2 != '0)) begin
      if (BYPASS && wr_ok && (bus.wa == bus.ra2)) begin
        bus.rd2 = bus.wd;
      end else begin
        bus.rd2 = regs[bus.ra2];
      end
    end
  end

  assign bus.ready = ready_q;
endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file (BYPASS=1): clear timing, x0, write/read, bypass,
// reset during clear and writes ignored while clearing.
module tb_reg_file;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int unsigned total  = 0;
  int unsigned passed = 0;
  int unsigned fails  = 0;

  reg_file_if #(.XLEN(32), .NREG(32)) bus ();

  reg_file #(.XLEN(32), .NREG(32), .BYPASS(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    bus.ra1 = '0;
    bus.ra2 = '0;
    bus.we  = 1'b0;
    bus.wa  = '0;
    bus.wd  = '0;

    // T1 + T6: two reset cycles, then 31 clear edges with a write attempted throughout
    rst = 1'b1;
    tick();
    tick();
    chk("reset_ready", 32'(bus.ready), 32'd0);
    rst     = 1'b0;
    bus.we  = 1'b1;
    bus.wa  = 5'd3;
    bus.wd  = 32'd99;
    bus.ra1 = 5'd3;
    bus.ra2 = 5'd3;
    #1;
    chk("clear_rd1_masked", bus.rd1, 32'd0);
    chk("clear_rd2_masked", bus.rd2, 32'd0);
    for (int i = 1; i <= 30; i++) begin
      tick();
      chk($sformatf("clear_ready_%0d", i), 32'(bus.ready), 32'd0);
    end
    tick();
    chk("clear_ready_31", 32'(bus.ready), 32'd1);
    bus.we = 1'b0;
    for (int a = 0; a < 32; a++) begin
      bus.ra1 = 5'(a);
      #1;
      chk($sformatf("cleared_x%0d", a), bus.rd1, 32'd0);
    end

    // T2: write x5, bypass visible before the edge, stored after it
    bus.we  = 1'b1;
    bus.wa  = 5'd5;
    bus.wd  = 32'hDEADBEEF;
    bus.ra1 = 5'd5;
    bus.ra2 = 5'd5;
    #1;
    chk("t2_bypass_rd1", bus.rd1, 32'hDEADBEEF);
    chk("t2_bypass_rd2", bus.rd2, 32'hDEADBEEF);
    tick();
    bus.we = 1'b0;
    #1;
    chk("t2_rd1", bus.rd1, 32'hDEADBEEF);
    chk("t2_rd2", bus.rd2, 32'hDEADBEEF);

    // T3: x0 write ignored, never bypassed
    bus.we  = 1'b1;
    bus.wa  = 5'd0;
    bus.wd  = 32'hFFFFFFFF;
    bus.ra1 = 5'd0;
    bus.ra2 = 5'd5;
    #1;
    chk("t3_x0_during_write", bus.rd1, 32'd0);
    tick();
    bus.we = 1'b0;
    #1;
    chk("t3_x0_after", bus.rd1, 32'd0);
    chk("t3_x5_kept", bus.rd2, 32'hDEADBEEF);

    // T4: x7=20, x3=40, then overwrite x7 with 30 while reading it
    bus.we = 1'b1;
    bus.wa = 5'd7;
    bus.wd = 32'd20;
    tick();
    bus.wa = 5'd3;
    bus.wd = 32'd40;
    tick();
    bus.wa  = 5'd7;
    bus.wd  = 32'd30;
    bus.ra1 = 5'd7;
    bus.ra2 = 5'd3;
    #1;
    chk("t4_bypass_rd1", bus.rd1, 32'd30);
    chk("t4_rd2_x3", bus.rd2, 32'd40);
    tick();
    bus.we = 1'b0;
    #1;
    chk("t4_x7_stored", bus.rd1, 32'd30);

    // Top register boundary
    bus.we  = 1'b1;
    bus.wa  = 5'd31;
    bus.wd  = 32'h1234_5678;
    tick();
    bus.we  = 1'b0;
    bus.ra1 = 5'd31;
    bus.ra2 = 5'd7;
    #1;
    chk("x31_rd1", bus.rd1, 32'h1234_5678);
    chk("x7_rd2", bus.rd2, 32'd30);

    // T5: x9=50, then restart, reset again at clear step 10
    bus.we = 1'b1;
    bus.wa = 5'd9;
    bus.wd = 32'd50;
    tick();
    bus.we  = 1'b0;
    bus.ra1 = 5'd9;
    #1;
    chk("t5_x9_written", bus.rd1, 32'd50);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_ready_after_rst", 32'(bus.ready), 32'd0);
    chk("t5_rd1_masked", bus.rd1, 32'd0);
    for (int i = 1; i <= 10; i++) begin
      tick();
    end
    chk("t5_step10_ready", 32'(bus.ready), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      chk($sformatf("t5_ready_%0d", i), 32'(bus.ready), 32'd0);
    end
    tick();
    chk("t5_ready_31", 32'(bus.ready), 32'd1);
    chk("t5_x9_cleared", bus.rd1, 32'd0);
    bus.ra1 = 5'd31;
    bus.ra2 = 5'd5;
    #1;
    chk("t5_x31_cleared", bus.rd1, 32'd0);
    chk("t5_x5_cleared", bus.rd2, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
